// File: rtl/result_wb_queue.sv
// result_wb_queue: small write-back FIFO between a fixed-latency functional
// unit and the commit-file write port. The producer never stalls; results
// that arrive while the queue is full (and nothing pops) are dropped and
// flagged via a sticky overflow bit. Per-hart flush kills stored entries,
// which then drain one per cycle without generating a write.

module result_wb_queue #(
  parameter int RV       = 64,
  parameter int LNCOMMIT = 5,
  parameter int NHART    = 1,
  parameter int DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [RV-1:0]                 in_result_i,
  input  logic [LNCOMMIT-1:0]           in_rd_i,
  input  logic [NHART-1:0]              in_makes_rd_i,
  input  logic [NHART-1:0]              flush_i,
  output logic                          wr_valid_o,
  input  logic                          wr_ready_i,
  output logic [RV-1:0]                 wr_data_o,
  output logic [LNCOMMIT-1:0]           wr_rd_o,
  output logic [NHART-1:0]              wr_hart_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [RV-1:0]       data_q [DEPTH];
  logic [LNCOMMIT-1:0] rd_q   [DEPTH];
  logic [NHART-1:0]    hart_q [DEPTH];
  logic [DEPTH-1:0]    live_q, live_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;

  logic empty, full, head_live;
  logic arrive, push, pop, drop;

  // Queue control: pop/push decisions, flush kill, pointer and count update.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_C);
    head_live = live_q[head_q];
    // A killed head leaves without a write; a live head leaves on handshake.
    pop       = !empty && (!head_live || wr_ready_i);
    // A result whose own hart is being flushed this cycle never enters.
    arrive    = (|in_makes_rd_i) && !(|(in_makes_rd_i & flush_i));
    // Full is still accepting when the head slot is freed on the same edge.
    push      = arrive && (!full || pop);
    drop      = arrive && full && !pop;

    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (|(hart_q[i] & flush_i)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = 1'b1;

    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | drop;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      live_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage; never read while its slot is unoccupied, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[tail_q] <= in_result_i;
      rd_q[tail_q]   <= in_rd_i;
      hart_q[tail_q] <= in_makes_rd_i;
    end
  end

  // Outputs come only from registers; payload forced to zero when empty.
  always_comb begin
    wr_valid_o = !empty && head_live;
    wr_data_o  = empty ? '0 : data_q[head_q];
    wr_rd_o    = empty ? '0 : rd_q[head_q];
    wr_hart_o  = empty ? '0 : hart_q[head_q];
    count_o    = count_q;
    overflow_o = overflow_q;
  end

endmodule

// File: doc/result_wb_queue.md
RESULT_WB_QUEUE -- requirements
Module: result_wb_queue

Interface
REQ-001 Parameter RV, default 64, data width of a result.
REQ-002 Parameter LNCOMMIT, default 5, commit-register index width.
REQ-003 Parameter NHART, default 1, number of harts; hart fields are one-hot, NHART bits.
REQ-004 Parameter DEPTH, default 4, FIFO entries (power of two, at least 2).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_result  in  RV  result from a fixed-latency functional unit (e.g. shifter).
REQ-008 in_rd  in  LNCOMMIT  destination commit register of in_result.
REQ-009 in_makes_rd  in  NHART  one-hot hart of a valid result; all-zero means no result.
REQ-010 flush  in  NHART  per-hart kill of queued and arriving results.
REQ-011 wr_valid  out  1  commit-file write request.
REQ-012 wr_ready  in  1  commit-file write port accepts this cycle.
REQ-013 wr_data  out  RV  write data (head entry).
REQ-014 wr_rd  out  LNCOMMIT  write register index (head entry).
REQ-015 wr_hart  out  NHART  one-hot hart of the head entry.
REQ-016 count  out  log2(DEPTH)+1  occupied entries, including killed ones not yet drained.
REQ-017 overflow  out  1  sticky; set when a valid result is dropped.

Function
REQ-018 The producer cannot stall; every cycle with in_makes_rd!=0 is an enqueue attempt.
REQ-019 Enqueue writes {in_result, in_rd, in_makes_rd, live=1} at the tail on the rising edge.
REQ-020 Write latency: a result enqueued into an empty queue at edge N drives wr_valid=1 in the cycle after N; no combinational input-to-output path.
REQ-021 wr_valid = head entry present AND live; wr_data/wr_rd/wr_hart reflect the head entry whenever the queue is non-empty.
REQ-022 Dequeue on the edge where wr_valid&wr_ready; the head pointer advances by 1 modulo DEPTH.
REQ-023 A killed (live=0) head entry is popped on the next edge without a write, one entry per cycle, regardless of wr_ready.
REQ-024 Simultaneous enqueue and dequeue (or killed-head pop) leaves count unchanged and is legal when full.
REQ-025 Enqueue while count==DEPTH with no pop in that cycle: the result is dropped, queue unchanged, overflow set to 1.
REQ-026 overflow remains 1 until reset.
REQ-027 flush[h]=1: every stored entry with hart h is marked live=0 on that edge.
REQ-028 An arriving result whose in_makes_rd matches a flush bit in the same cycle is not enqueued and does not set overflow.
REQ-029 A head entry that completes wr_valid&wr_ready in the same cycle as its flush counts as written and is popped.
REQ-030 Head and tail pointers wrap modulo DEPTH; full/empty are distinguished by count, never by pointer equality alone.
REQ-031 wr_valid never depends on wr_ready; once asserted, the head entry stays stable until popped or flushed.

Reset
REQ-032 While reset is low: count=0, overflow=0, wr_valid=0, head and tail pointers 0, all live bits 0.
REQ-033 wr_data, wr_rd, and wr_hart are 0 during reset.
REQ-034 Reset asserted mid-operation discards all entries immediately (asynchronous); the first enqueue after release is accepted on the first rising edge with reset high.

Verification
REQ-035 Single result: in_result=64'h0123_4567_89AB_CDEF, in_rd=7, in_makes_rd=1, wr_ready=1 -> wr_valid=1 the next cycle with wr_rd=7, wr_data matches, count returns to 0 the cycle after.
REQ-036 Backpressure/full: wr_ready=0, enqueue 5 results rd=1..5 with DEPTH=4 -> count=4, overflow=1, rd=5 dropped; then wr_ready=1 -> writes rd=1,2,3,4 in order on 4 consecutive cycles.
REQ-037 Full plus simultaneous enqueue/dequeue: count=4, wr_ready=1, enqueue rd=9 -> count stays 4, overflow stays 0, rd=9 is written 4 cycles later.
REQ-038 Flush (NHART=2): queue holds hart0 rd=1, hart1 rd=2, hart0 rd=3 with wr_ready=0; pulse flush=2'b10; then wr_ready=1 -> writes rd=1, one idle cycle with wr_valid=0 for the killed entry, then rd=3.
REQ-039 Same-cycle flush and arrival: in_makes_rd=2'b01, flush=2'b01 -> nothing enqueued, count unchanged, overflow=0.
REQ-040 Reset mid-stream: reset low with count=3 -> count=0, wr_valid=0 without waiting for a clock edge; after release, a new enqueue rd=4 is written with correct data.
